// File: rtl/quant_seq.sv
// Two-pass sequencer for the quant_pre fp32-to-fixed datapath: pass 1 finds the
// largest-magnitude word of the buffer, pass 2 streams the buffer through quant_pre.
module quant_seq #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [31:0]       i_rd_data,
    output logic [31:0]       o_qp_max,
    output logic [31:0]       o_qp_act,
    input  logic [31:0]       i_qp_act,
    input  logic [31:0]       i_qp_unit,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic [31:0]       o_unit,
    output logic [31:0]       o_max
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SCAN_DRAIN,
        QUANT,
        QUANT_DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rdCnt_q, rdCnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              drain_q, drain_d;
    logic [31:0]       max_q, max_d;
    logic [31:0]       unit_q, unit_d;
    logic              firstWr_q, firstWr_d;
    logic              scanVld_q;
    logic              vld1_q, vld2_q;
    logic [ADDR_W-1:0] addr1_q, addr2_q;
    logic              startJob;
    logic              rdEn;
    logic              lastRd;

    // Next-state logic; the read counter is cleared when a pass starts or ends.
    always_comb begin
        state_d  = state_q;
        rdCnt_d  = rdCnt_q;
        len_d    = len_q;
        drain_d  = drain_q;
        startJob = 1'b0;
        rdEn     = 1'b0;
        lastRd   = (rdCnt_q == len_q - 1'b1);
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    startJob = 1'b1;
                    len_d    = i_len;
                    rdCnt_d  = '0;
                    state_d  = (i_len != '0) ? SCAN : DONE;
                end
            end
            SCAN, QUANT: begin
                rdEn = 1'b1;
                if (lastRd) begin
                    rdCnt_d = '0;
                    drain_d = 1'b0;
                    state_d = (state_q == SCAN) ? SCAN_DRAIN : QUANT_DRAIN;
                end else begin
                    rdCnt_d = rdCnt_q + 1'b1;
                end
            end
            SCAN_DRAIN: state_d = QUANT;
            QUANT_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Magnitude compare ignores the sign; ties keep the earlier word.
    always_comb begin
        max_d     = max_q;
        unit_d    = unit_q;
        firstWr_d = firstWr_q;
        if (startJob) begin
            max_d = '0;
        end else if (scanVld_q && (i_rd_data[30:0] > max_q[30:0])) begin
            max_d = i_rd_data;
        end
        if (startJob) begin
            firstWr_d = 1'b1;
        end else if (vld2_q) begin
            firstWr_d = 1'b0;
        end
        if (vld2_q && firstWr_q) unit_d = i_qp_unit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rdCnt_q   <= '0;
            len_q     <= '0;
            drain_q   <= 1'b0;
            max_q     <= '0;
            unit_q    <= '0;
            firstWr_q <= 1'b0;
            scanVld_q <= 1'b0;
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
            addr1_q   <= '0;
            addr2_q   <= '0;
        end else begin
            state_q   <= state_d;
            rdCnt_q   <= rdCnt_d;
            len_q     <= len_d;
            drain_q   <= drain_d;
            max_q     <= max_d;
            unit_q    <= unit_d;
            firstWr_q <= firstWr_d;
            scanVld_q <= rdEn && (state_q == SCAN);
            vld1_q    <= rdEn && (state_q == QUANT);
            vld2_q    <= vld1_q;
            addr1_q   <= rdCnt_q;
            addr2_q   <= addr1_q;
        end
    end

    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_rd_en   = rdEn;
    assign o_rd_addr = rdCnt_q;
    assign o_qp_max  = max_q;
    assign o_qp_act  = i_rd_data;
    assign o_wr_en   = vld2_q;
    assign o_wr_addr = addr2_q;
    assign o_wr_data = i_qp_act;
    assign o_unit    = unit_q;
    assign o_max     = max_q;

endmodule

// File: tb/tb_quant_seq.sv
// Directed bench for quant_seq with an activation SRAM model and a one-cycle
// quant_pre stand-in (act XOR 0xFFFF, unit = max >> 1).
module tb_quant_seq;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [ADDR_W-1:0] i_len;
    logic              o_busy, o_done, o_rd_en, o_wr_en;
    logic [ADDR_W-1:0] o_rd_addr, o_wr_addr;
    logic [31:0]       rdData, o_qp_max, o_qp_act, qpAct, qpUnit;
    logic [31:0]       o_wr_data, o_unit, o_max;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int          now = 0;
    int          startNow, wrBase, doneBase, rdBase;
    int          errors = 0;
    int          checks = 0;
    int          rdTotal = 0;
    int          wrCycQ[$];
    int          wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    int          doneCycQ[$];
    int          savedWr;

    quant_seq #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_data(rdData), .o_qp_max(o_qp_max), .o_qp_act(o_qp_act),
        .i_qp_act(qpAct), .i_qp_unit(qpUnit), .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_unit(o_unit), .o_max(o_max)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        now    <= now + 1;
        rdData <= o_rd_en ? mem[o_rd_addr] : 32'h0;
        qpAct  <= o_qp_act ^ 32'h0000_FFFF;
        qpUnit <= {1'b0, o_qp_max[31:1]};
    end

    always @(negedge clk) begin
        if (o_wr_en) begin
            wrCycQ.push_back(now);
            wrAddrQ.push_back(int'(o_wr_addr));
            wrDataQ.push_back(o_wr_data);
        end
        if (o_done) doneCycQ.push_back(now);
        if (o_rd_en) rdTotal++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge of cycle 1.
    task automatic applyStimulus(input int len);
        i_start  = 1'b1;
        i_len    = ADDR_W'(len);
        startNow = now;
        wrBase   = wrCycQ.size();
        doneBase = doneCycQ.size();
        rdBase   = rdTotal;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic waitUntil(input int cyc);
        while (now - startNow < cyc) @(negedge clk);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(o_busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(o_done), 32'h0);
        checkOutput({tag, "_rd_en"}, 32'(o_rd_en), 32'h0);
        checkOutput({tag, "_rd_addr"}, 32'(o_rd_addr), 32'h0);
        checkOutput({tag, "_wr_en"}, 32'(o_wr_en), 32'h0);
        checkOutput({tag, "_wr_addr"}, 32'(o_wr_addr), 32'h0);
        checkOutput({tag, "_unit"}, o_unit, 32'h0);
        checkOutput({tag, "_max"}, o_max, 32'h0);
        checkOutput({tag, "_qp_max"}, o_qp_max, 32'h0);
    endtask

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_len   = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic L=3 job
        mem[0] = 32'h3F80_0000; mem[1] = 32'hC040_0000; mem[2] = 32'h3E80_0000;
        applyStimulus(3);
        waitUntil(5);
        checkOutput("l3_max_c5", o_max, 32'hC040_0000);
        checkOutput("l3_qpmax_c5", o_qp_max, 32'hC040_0000);
        waitUntil(11);
        checkOutput("l3_wr_count", 32'(wrCycQ.size() - wrBase), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (wrBase + i < wrCycQ.size()) begin
                checkOutput($sformatf("l3_wr%0d_cyc", i), 32'(wrCycQ[wrBase+i] - startNow), 32'(7 + i));
                checkOutput($sformatf("l3_wr%0d_addr", i), 32'(wrAddrQ[wrBase+i]), 32'(i));
            end
        end
        if (wrBase + 2 < wrCycQ.size()) begin
            checkOutput("l3_wr0_data", wrDataQ[wrBase], 32'h3F80_FFFF);
            checkOutput("l3_wr1_data", wrDataQ[wrBase+1], 32'hC040_FFFF);
            checkOutput("l3_wr2_data", wrDataQ[wrBase+2], 32'h3E80_FFFF);
        end
        checkOutput("l3_done_count", 32'(doneCycQ.size() - doneBase), 32'd1);
        if (doneCycQ.size() > doneBase)
            checkOutput("l3_done_cyc", 32'(doneCycQ[doneBase] - startNow), 32'd10);
        checkOutput("l3_rd_count", 32'(rdTotal - rdBase), 32'd6);
        checkOutput("l3_unit", o_unit, 32'h6020_0000);
        checkOutput("l3_busy_idle", 32'(o_busy), 32'h0);

        // Tie on magnitude keeps the first word
        mem[0] = 32'h4000_0000; mem[1] = 32'hC000_0000;
        applyStimulus(2);
        waitUntil(10);
        checkOutput("tie_max", o_max, 32'h4000_0000);
        checkOutput("tie_unit", o_unit, 32'h2000_0000);
        if (doneCycQ.size() > doneBase)
            checkOutput("tie_done_cyc", 32'(doneCycQ[doneBase] - startNow), 32'd8);
        else
            checkOutput("tie_done_seen", 32'd0, 32'd1);

        // Zero-length job
        applyStimulus(0);
        waitUntil(4);
        checkOutput("l0_done_count", 32'(doneCycQ.size() - doneBase), 32'd1);
        if (doneCycQ.size() > doneBase)
            checkOutput("l0_done_cyc", 32'(doneCycQ[doneBase] - startNow), 32'd1);
        checkOutput("l0_rd_count", 32'(rdTotal - rdBase), 32'd0);
        checkOutput("l0_wr_count", 32'(wrCycQ.size() - wrBase), 32'd0);
        checkOutput("l0_max", o_max, 32'h0);

        // Start pulses during SCAN and DONE are ignored
        mem[0] = 32'h0000_0001; mem[1] = 32'hBF00_0000;
        mem[2] = 32'h4120_0000; mem[3] = 32'h7F7F_FFFF;
        applyStimulus(4);
        waitUntil(2);
        i_start = 1'b1; i_len = 10'd4;
        @(negedge clk);
        i_start = 1'b0;
        waitUntil(12);
        checkOutput("ign_done_now", 32'(o_done), 32'h1);
        i_start = 1'b1; i_len = 10'd4;
        @(negedge clk);
        i_start = 1'b0;
        checkOutput("ign_idle_c13", 32'(o_busy), 32'h0);
        waitUntil(30);
        checkOutput("ign_done_count", 32'(doneCycQ.size() - doneBase), 32'd1);
        checkOutput("ign_wr_count", 32'(wrCycQ.size() - wrBase), 32'd4);
        checkOutput("ign_max", o_max, 32'h7F7F_FFFF);

        // Back-to-back: L=1 then L=4 started in the first IDLE cycle
        mem[0] = 32'h3F80_0000;
        applyStimulus(1);
        waitUntil(4);
        mem[0] = 32'h0000_0001;
        waitUntil(7);
        checkOutput("b2b_first_idle", 32'(o_busy), 32'h0);
        if (doneCycQ.size() > doneBase)
            checkOutput("b2b_l1_done_cyc", 32'(doneCycQ[doneBase] - startNow), 32'd6);
        checkOutput("b2b_l1_unit", o_unit, 32'h1FC0_0000);
        applyStimulus(4);
        waitUntil(8);
        checkOutput("b2b_unit_c8", o_unit, 32'h1FC0_0000);
        checkOutput("b2b_wr_en_c8", 32'(o_wr_en), 32'h1);
        waitUntil(9);
        checkOutput("b2b_unit_c9", o_unit, 32'h3FBF_FFFF);
        waitUntil(14);
        if (doneCycQ.size() > doneBase)
            checkOutput("b2b_l4_done_cyc", 32'(doneCycQ[doneBase] - startNow), 32'd12);
        else
            checkOutput("b2b_l4_done_seen", 32'd0, 32'd1);
        if (wrCycQ.size() > wrBase)
            checkOutput("b2b_wr0_data", wrDataQ[wrBase], 32'h0000_FFFE);

        // Reset in the middle of QUANT with L=8
        for (int i = 0; i < 8; i++) mem[i] = 32'h4000_0000 + 32'(i);
        applyStimulus(8);
        waitUntil(13);
        #2;
        rst = 1'b1;
        #1;
        checkIdleOutputs("midrst");
        savedWr = wrCycQ.size();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("midrst_no_wr", 32'(wrCycQ.size() - savedWr), 32'd0);
        mem[0] = 32'h3F00_0000;
        applyStimulus(1);
        waitUntil(8);
        if (doneCycQ.size() > doneBase)
            checkOutput("post_rst_done_cyc", 32'(doneCycQ[doneBase] - startNow), 32'd6);
        else
            checkOutput("post_rst_done_seen", 32'd0, 32'd1);
        checkOutput("post_rst_max", o_max, 32'h3F00_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quant_seq.md
# quant_seq

Two-pass sequencer for the `quant_pre` fp32-to-fixed datapath in the CNN quantisation path. Pass 1 scans an activation buffer to find the largest-magnitude fp32 value. Pass 2 streams the same buffer through an external `quant_pre` instance, using that value as `i_max`, and writes each result to an output buffer. It sits between the activation SRAM, the `quant_pre` instance and the quantised-activation SRAM, and is started by the layer controller.

## Interface
Parameters:
- ADDR_W, 10, address width of the input and output buffers; max job length is 2^ADDR_W-1 words.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  job start pulse; sampled only in IDLE.
- i_len  in  ADDR_W  number of activations; sampled with i_start.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_rd_en  out  1  activation SRAM read enable.
- o_rd_addr  out  ADDR_W  activation SRAM read address.
- i_rd_data  in  32  fp32 read data, valid the cycle after o_rd_en.
- o_qp_max  out  32  to `quant_pre` i_max; held stable for all of pass 2.
- o_qp_act  out  32  to `quant_pre` i_activation; combinational copy of i_rd_data.
- i_qp_act  in  32  from `quant_pre` o_activation.
- i_qp_unit  in  32  from `quant_pre` o_unit.
- o_wr_en  out  1  output SRAM write enable.
- o_wr_addr  out  ADDR_W  output SRAM write address.
- o_wr_data  out  32  combinational copy of i_qp_act.
- o_unit  out  32  i_qp_unit captured on the first write of the job.
- o_max  out  32  result of the pass-1 scan.

## Operation
- States:
  - IDLE: if i_start=1 and i_len≠0, go to SCAN; if i_start=1 and i_len=0, go to DONE; otherwise stay.
  - SCAN → SCAN_DRAIN after i_len reads.
  - SCAN_DRAIN (1 cycle) → QUANT.
  - QUANT → QUANT_DRAIN after i_len reads.
  - QUANT_DRAIN (2 cycles) → DONE.
  - DONE (1 cycle, o_done=1) → IDLE.
- i_start is ignored outside IDLE. i_len is latched at start.
- Reads (SCAN and QUANT): o_rd_en=1 and o_rd_addr runs 0..len-1, one per cycle. The address counter clears on entry to each pass.
- Max compare:
  - The running max clears to 0 at start.
  - A returned word d replaces the max if d[30:0] > max[30:0], compared unsigned on magnitude; the sign bit is ignored.
  - On a tie, the earlier word is kept.
  - The stored max is the full original 32-bit word, including its sign.
- o_qp_max is driven from the max register. It is frozen from SCAN_DRAIN exit until the next start.
- Pass 2 pipeline:
  - Read issued in cycle c; data presented on o_qp_act in cycle c+1.
  - `quant_pre` registers it; its result is valid in cycle c+2.
  - The controller asserts o_wr_en in cycle c+2, with o_wr_addr = read address delayed by 2.
  - Valid and address are carried in 2-stage shift registers.
- o_unit loads i_qp_unit on the first o_wr_en of the job and holds it until the next job's first write.
- No backpressure: writes are issued unconditionally.

## Timing
- Reset values: state IDLE; all outputs 0 (o_busy, o_done, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_unit, o_max, o_qp_max). The pipeline valid bits are 0.
- Cycle numbering: cycle 1 is the cycle after the edge that samples i_start. L = i_len.
  - SCAN reads: cycles 1..L.
  - SCAN_DRAIN: cycle L+1. o_max is final at the end of this cycle.
  - QUANT reads: cycles L+2..2L+1.
  - o_qp_act valid: cycles L+3..2L+2.
  - Writes: cycles L+4..2L+3.
  - QUANT_DRAIN: cycles 2L+2..2L+3.
  - o_done: cycle 2L+4.
  - Back in IDLE: cycle 2L+5, where a new i_start is accepted.
- L=0: o_done in cycle 1; no reads or writes; o_max=0.
- Reset mid-job: return to IDLE immediately. Writes are suppressed from the reset assertion onward; partial output-buffer contents are don't-care.

## Test plan
- Reset: assert rst mid-QUANT with L=8 → all outputs 0 on the same cycle, no further o_wr_en, and i_start after reset is accepted normally.
- L=3, buffer {0x3F800000, 0xC0400000, 0x3E800000} → o_max=0xC0400000 in cycle 5; writes in cycles 7, 8, 9 to addresses 0, 1, 2; o_done in cycle 10.
- Tie: L=2, {0x40000000, 0xC0000000} → o_max=0x40000000, the first word kept.
- L=0 → o_done in cycle 1; o_rd_en and o_wr_en never asserted.
- i_start pulsed during SCAN and during DONE → ignored; exactly one job runs with one o_done.
- Back-to-back: L=1 job, then a new i_start in the first IDLE cycle with L=4 → second job's o_done 2*4+4 cycles after its start edge; o_unit updates on that job's first write.
